// File: rtl/mult_pkg.sv
// mult_pkg: shared types and width helpers for the radix-4 Booth sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [2:0] {B_ZERO, B_P1, B_P2, B_M1, B_M2} digit_t;
  function automatic int n_dig(int w);
    return w / 2;
  endfunction
  function automatic int acc_w(int w);
    return w + 2;
  endfunction
  function automatic int add_w(int w);
    return w + 4;
  endfunction
endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder, multiplier bit triplet -> partial-product controls
//   trip_i : {q[i+1], q[i], q[i-1]}
//   neg_o  : subtract the multiple   two_o : use 2M instead of M   zero_o : add nothing
module booth_r4_enc
  import mult_pkg::*;
(
  input  logic [2:0] trip_i,
  output logic       neg_o,
  output logic       two_o,
  output logic       zero_o
);
  digit_t digit;
  always_comb begin
    digit = (trip_i == 3'b000 || trip_i == 3'b111) ? B_ZERO :
            (trip_i == 3'b011) ? B_P2 :
            (trip_i == 3'b100) ? B_M2 :
            trip_i[2] ? B_M1 : B_P1;
  end
  assign neg_o  = digit inside {B_M1, B_M2};
  assign two_o  = digit inside {B_P2, B_M2};
  assign zero_o = digit == B_ZERO;
endmodule

// File: rtl/cla4.sv
// cla4: 4-bit carry-lookahead adder slice
//   a_i, b_i : addends     cin_i : carry in
//   sum_o    : sum         cout_o : carry out
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | ((&p[1:0]) & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | ((&p[2:1]) & g[0]) | ((&p[2:0]) & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | ((&p[3:2]) & g[1]) | ((&p[3:1]) & g[0]) | ((&p[3:0]) & c[0]);
  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential signed multiplier, one radix-4 Booth digit per cycle
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only when idle
//   multiplicand : signed M      multiplier : signed Q
//   busy         : operation in flight (through the done cycle)
//   done         : one-cycle pulse, product valid in the same cycle
//   product      : signed M*Q, held until the next done or reset
module booth_r4_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int N_DIG = n_dig(WIDTH);
  localparam int ACC_W = acc_w(WIDTH);
  localparam int ADD_W = add_w(WIDTH);
  localparam int NBLK  = ADD_W / 4;
  localparam int CNT_W = $clog2(N_DIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIG - 1);
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WIDTH:0]       q_q, q_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 done_q;
  logic                 neg, two, zero, accept;
  logic [ACC_W-1:0]     m_ext, mag, op;
  logic [ADD_W-1:0]     add_a, add_b, sum;
  logic [NBLK:0]        c;
  logic signed [ACC_W+WIDTH:0] sh;
  logic                 add_unused;
  booth_r4_enc u_enc (.trip_i(q_q[2:0]), .neg_o(neg), .two_o(two), .zero_o(zero));
  assign m_ext = {{2{m_q[WIDTH-1]}}, m_q};
  assign mag   = two ? m_ext << 1 : m_ext;
  // Subtraction is ~operand plus a carry-in of 1; a zero digit must not inject that carry.
  assign op    = zero ? '0 : neg ? ~mag : mag;
  assign c[0]  = neg & ~zero;
  assign add_a = {{2{acc_q[ACC_W-1]}}, acc_q};
  assign add_b = {{2{op[ACC_W-1]}}, op};
  for (genvar g = 0; g < NBLK; g++) begin : g_add
    cla4 u_cla (.a_i(add_a[4*g+:4]), .b_i(add_b[4*g+:4]), .cin_i(c[g]), .sum_o(sum[4*g+:4]), .cout_o(c[g+1]));
  end
  assign add_unused = ^{c[NBLK], sum[ADD_W-1:ACC_W]};
  assign sh    = $signed({sum[ACC_W-1:0], q_q}) >>> 2;
  assign acc_d = sh[ACC_W+WIDTH -: ACC_W];
  assign q_d   = sh[WIDTH:0];
  // The done cycle also blocks acceptance, so held start restarts one cycle after done.
  assign accept = state_q == IDLE && start && !done_q;
  always_comb begin
    state_d = state_q == IDLE ? (accept ? CALC : IDLE) :
              state_q == CALC ? (cnt_q == LAST ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DONE;
      if (accept) begin
        m_q   <= multiplicand;
        acc_q <= '0;
        q_q   <= {multiplier, 1'b0};
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_d;
        q_q   <= q_d;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == DONE) product_q <= {acc_q[WIDTH-1:0], q_q[WIDTH:1]};
    end
  end
  assign busy    = state_q != IDLE || done_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: scoreboard bench for booth_r4_seq_mult
module tb_booth_r4_seq_mult;
  typedef struct {
    logic [15:0] p;
    int          e;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy, done;
  logic [15:0] product;
  exp_t        sb[$];
  exp_t        x;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  booth_r4_seq_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] ref_mul(input logic signed [7:0] m, input logic signed [7:0] q);
    int r;
    r = int'(m) * int'(q);
    return r[15:0];
  endfunction
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        chk("product", 32'(product), 32'(x.p));
        chk("done_edge", cyc, x.e);
      end
    end
  end
  task automatic issue(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    sb.push_back('{ref_mul(m, q), cyc + 1 + 5});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    int s;
    logic [7:0] corner [8] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'hC0, 8'h3F};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    issue(8'd7, 8'd3);
    for (int i = 0; i < 6; i++) begin
      chk("busy_in_flight", busy, 1);
      @(negedge clk);
    end
    drain();
    issue(8'h80, 8'h80); drain();
    issue(8'h80, 8'h7F); drain();
    issue(8'h7F, 8'h7F); drain();
    issue(8'h00, 8'hFF); drain();
    issue(8'd11, 8'd13);
    @(negedge clk);
    start = 1'b1;
    multiplicand = 8'd100;
    multiplier = 8'd99;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    issue(8'd45, 8'hD3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(8'hF6, 8'd12); drain();
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      multiplicand = 8'(8'd17 * (i + 1) - 8'd60);
      multiplier = 8'(8'd90 - 8'd53 * i);
      sb.push_back('{ref_mul(multiplicand, multiplier), s + 7 * i + 5});
      @(negedge clk);
      if (i < 2) repeat (6) @(negedge clk);
    end
    start = 1'b0;
    drain();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        issue(corner[i], corner[j]);
        drain();
      end
    for (int k = 0; k < 2000; k++) begin
      issue(8'($urandom), 8'($urandom));
      drain();
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
